// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-bank BIST sequencer.
//   state_t       : sequencer FSM states
//   FM_*          : bit positions of the per-gate sticky fail flags
//   LFSR_TAPS     : Galois feedback taps for the 16-bit operand LFSR
//   EXH_VECS      : number of leading exhaustive (00,01,10,11) vectors
//   lfsr_step()   : one right-shift Galois step
package gate_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRIVE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam int FM_NAND = 0;
   localparam int FM_NOT  = 1;
   localparam int FM_AND  = 2;
   localparam int FM_OR   = 3;
   localparam int FM_XOR  = 4;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          EXH_VECS  = 4;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Galois LFSR feeding pseudo-random operands to the BIST sequencer.
//   clk, rst : clock, synchronous active-high reset (reset loads seed)
//   load     : reload with seed
//   seed     : load value (must be nonzero)
//   step2    : advance two steps this cycle
//   cur      : current state
//   nxt1     : state one step ahead (second operand of a vector)
module bist_lfsr16
   import gate_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step2,
   output logic [15:0] cur,
   output logic [15:0] nxt1
);

   logic [15:0] state_q;

   assign cur  = state_q;
   assign nxt1 = lfsr_step(state_q);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         state_q <= seed;
      end else if (step2) begin
         state_q <= lfsr_step(nxt1);
      end
   end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the NAND/NOT/AND/OR/XOR gate bank. Drives operand
// vectors, waits SETTLE cycles, checks the five gate outputs and
// accumulates per-gate fail flags and a failing-vector count.
//   clk, rst      : clock, synchronous active-high reset
//   start         : run request, honoured only in IDLE
//   busy, done    : run in progress / one-cycle completion pulse
//   pass          : last completed run had no failing vector
//   vec_idx       : index of the vector on a_o/b_o
//   a_o, b_o      : operands to the gate bank
//   nand_i..xor_i : gate outputs under test
//   err_cnt       : vectors with at least one mismatching bit
//   fail_mask     : sticky per-gate fail flags (FM_* bit order)
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_LOAD  | new vector on a_o/b_o (registered on entry)
// ST_DRIVE | settle wait, SETTLE cycles
// ST_CHECK | compare gate outputs, update flags/count
// ST_DONE  | done pulse, pass valid
module gate_bist_ctrl
   import gate_bist_pkg::*;
#(
   parameter int          WIDTH     = 1,
   parameter int          NUM_VEC   = 4,
   parameter int          SETTLE    = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       vec_idx,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   input  logic [WIDTH-1:0] nand_i,
   input  logic [WIDTH-1:0] not_i,
   input  logic [WIDTH-1:0] and_i,
   input  logic [WIDTH-1:0] or_i,
   input  logic [WIDTH-1:0] xor_i,
   output logic [7:0]       err_cnt,
   output logic [4:0]       fail_mask
);

   localparam logic [3:0] SETTLE_M1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
   localparam logic [7:0] LAST_IDX  = 8'(NUM_VEC - 1);

   state_t      state_q, state_d;
   logic [3:0]  settle_cnt;
   logic        load_vec, lfsr_load, lfsr_step2, vec_bad;
   logic [7:0]  next_idx, err_next;
   logic [4:0]  gate_err;
   logic [15:0] lfsr_cur, lfsr_nxt1;
   logic        unused_lfsr_bits;

   bist_lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .seed  (LFSR_SEED),
      .step2 (lfsr_step2),
      .cur   (lfsr_cur),
      .nxt1  (lfsr_nxt1)
   );

   // Only the low WIDTH bits reach the operands.
   assign unused_lfsr_bits = ^{lfsr_cur, lfsr_nxt1};

   assign busy = (state_q == ST_LOAD) || (state_q == ST_DRIVE) || (state_q == ST_CHECK);
   assign done = (state_q == ST_DONE);

   always_comb begin
      gate_err           = '0;
      gate_err[FM_NAND]  = |(nand_i ^ ~(a_o & b_o));
      gate_err[FM_NOT]   = |(not_i  ^ ~a_o);
      gate_err[FM_AND]   = |(and_i  ^ (a_o & b_o));
      gate_err[FM_OR]    = |(or_i   ^ (a_o | b_o));
      gate_err[FM_XOR]   = |(xor_i  ^ (a_o ^ b_o));
      vec_bad            = |gate_err;
      err_next           = err_cnt + {7'd0, vec_bad};
   end

   // Operands are registered on the edge entering LOAD so they are valid
   // for the whole LOAD cycle.
   always_comb begin
      state_d   = state_q;
      load_vec  = 1'b0;
      lfsr_load = 1'b0;
      next_idx  = vec_idx;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_LOAD;
               load_vec  = 1'b1;
               lfsr_load = 1'b1;
               next_idx  = 8'd0;
            end
         end
         ST_LOAD:  state_d = (SETTLE > 0) ? ST_DRIVE : ST_CHECK;
         ST_DRIVE: begin
            if (settle_cnt == 4'd0) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (vec_idx == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_LOAD;
               load_vec = 1'b1;
               next_idx = vec_idx + 8'd1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      lfsr_step2 = load_vec && (next_idx >= 8'(EXH_VECS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         settle_cnt <= 4'd0;
         vec_idx    <= 8'd0;
         a_o        <= '0;
         b_o        <= '0;
         err_cnt    <= 8'd0;
         fail_mask  <= 5'd0;
         pass       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            err_cnt   <= 8'd0;
            fail_mask <= 5'd0;
            pass      <= 1'b0;
         end
         if (load_vec) begin
            vec_idx <= next_idx;
            if (next_idx < 8'(EXH_VECS)) begin
               a_o <= {WIDTH{next_idx[1]}};
               b_o <= {WIDTH{next_idx[0]}};
            end else begin
               a_o <= lfsr_cur[WIDTH-1:0];
               b_o <= lfsr_nxt1[WIDTH-1:0];
            end
         end
         if (state_q == ST_LOAD) begin
            settle_cnt <= SETTLE_M1;
         end else if (state_q == ST_DRIVE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         if (state_q == ST_CHECK) begin
            fail_mask <= fail_mask | gate_err;
            err_cnt   <= err_next;
            if (vec_idx == LAST_IDX) pass <= (err_next == 8'd0);
         end
      end
   end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
module tb_gate_bist_ctrl;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  idx;
      int          cyc;
   } vec_t;

   typedef struct {
      int         err;
      logic [4:0] mask;
      logic       pass;
      int         cyc;
   } done_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   int   cyc = 0;
   int   fault0 = 0;
   int   n_vec = 0, n_mis = 0;

   vec_t  vq0[$], vq1[$];
   done_t dq0[$], dq1[$];
   int    done_cnt[2] = '{0, 0};
   bit    prev_busy[2] = '{0, 0};
   logic [7:0] prev_idx[2] = '{8'd0, 8'd0};

   // instance 0: WIDTH=1, NUM_VEC=4, SETTLE=1, injectable faults
   logic       busy0, done0, pass0;
   logic [7:0] idx0, err0;
   logic [4:0] mask0;
   logic [0:0] a0, b0, nand0, not0, and0, or0, xor0;

   assign nand0 = ~(a0 & b0) ^ ((fault0 == 2) ? 1'b1 : 1'b0);
   assign not0  = ~a0;
   assign and0  = a0 & b0;
   assign or0   = a0 | b0;
   assign xor0  = (fault0 == 1) ? 1'b0 : (a0 ^ b0);

   gate_bist_ctrl #(.WIDTH(1), .NUM_VEC(4), .SETTLE(1), .LFSR_SEED(16'hACE1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
      .vec_idx(idx0), .a_o(a0), .b_o(b0), .nand_i(nand0), .not_i(not0), .and_i(and0),
      .or_i(or0), .xor_i(xor0), .err_cnt(err0), .fail_mask(mask0)
   );

   // instance 1: WIDTH=16, NUM_VEC=6, SETTLE=0, golden gates
   logic        busy1, done1, pass1;
   logic [7:0]  idx1, err1;
   logic [4:0]  mask1;
   logic [15:0] a1, b1;

   gate_bist_ctrl #(.WIDTH(16), .NUM_VEC(6), .SETTLE(0), .LFSR_SEED(16'hACE1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
      .vec_idx(idx1), .a_o(a1), .b_o(b1), .nand_i(~(a1 & b1)), .not_i(~a1),
      .and_i(a1 & b1), .or_i(a1 | b1), .xor_i(a1 ^ b1), .err_cnt(err1), .fail_mask(mask1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic mon(input int inst, input logic busy, input logic done, input logic pass,
                      input logic [7:0] idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] err, input logic [4:0] mask);
      vec_t  v;
      done_t d;
      if (busy && (!prev_busy[inst] || idx != prev_idx[inst])) begin
         if ((inst == 0 ? vq0.size() : vq1.size()) == 0) begin
            chk($sformatf("unexpected_vec%0d", inst), 32'd1, 32'd0);
         end else begin
            v = (inst == 0) ? vq0.pop_front() : vq1.pop_front();
            chk($sformatf("vec%0d_idx", inst), {24'd0, idx}, {24'd0, v.idx});
            chk($sformatf("vec%0d_a", inst), {16'd0, a}, {16'd0, v.a});
            chk($sformatf("vec%0d_b", inst), {16'd0, b}, {16'd0, v.b});
            chk($sformatf("vec%0d_cycle", inst), cyc, v.cyc);
         end
      end
      if (done) begin
         done_cnt[inst]++;
         if ((inst == 0 ? dq0.size() : dq1.size()) == 0) begin
            chk($sformatf("unexpected_done%0d", inst), 32'd1, 32'd0);
         end else begin
            d = (inst == 0) ? dq0.pop_front() : dq1.pop_front();
            chk($sformatf("done%0d_cycle", inst), cyc, d.cyc);
            chk($sformatf("done%0d_err_cnt", inst), {24'd0, err}, d.err);
            chk($sformatf("done%0d_fail_mask", inst), {27'd0, mask}, {27'd0, d.mask});
            chk($sformatf("done%0d_pass", inst), {31'd0, pass}, {31'd0, d.pass});
            chk($sformatf("done%0d_busy", inst), {31'd0, busy}, 32'd0);
         end
      end
      prev_busy[inst] = busy;
      prev_idx[inst]  = idx;
   endtask

   always @(negedge clk) begin
      mon(0, busy0, done0, pass0, idx0, {15'd0, a0}, {15'd0, b0}, err0, mask0);
      mon(1, busy1, done1, pass1, idx1, a1, b1, err1, mask1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge: pushes the expected run, then pulses start so
   // the next posedge (absolute cycle t0) samples it.
   task automatic start_run(input int inst, input int exp_err, input logic [4:0] exp_mask,
                            output int t0);
      int    n, per;
      vec_t  v;
      done_t d;
      logic [7:0] kk;
      t0  = cyc + 1;
      n   = (inst == 0) ? 4 : 6;
      per = (inst == 0) ? 3 : 2;
      for (int k = 0; k < n; k++) begin
         kk    = 8'(k);
         v.idx = kk;
         v.cyc = t0 + k * per;
         if (k < 4) begin
            v.a = (inst == 0) ? {15'd0, kk[1]} : {16{kk[1]}};
            v.b = (inst == 0) ? {15'd0, kk[0]} : {16{kk[0]}};
         end else if (k == 4) begin
            v.a = 16'hACE1;
            v.b = 16'hE270;
         end else begin
            v.a = 16'h7138;
            v.b = 16'h389C;
         end
         if (inst == 0) vq0.push_back(v); else vq1.push_back(v);
      end
      d.err  = exp_err;
      d.mask = exp_mask;
      d.pass = (exp_err == 0);
      d.cyc  = t0 + n * per;
      if (inst == 0) dq0.push_back(d); else dq1.push_back(d);
      if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   initial begin
      int t0, t1, dc;

      // reset state
      tick(2);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_pass", {31'd0, pass0}, 32'd0);
      chk("rst_vec_idx", {24'd0, idx0}, 32'd0);
      chk("rst_ab", {30'd0, a0, b0}, 32'd0);
      chk("rst_err_cnt", {24'd0, err0}, 32'd0);
      chk("rst_fail_mask", {27'd0, mask0}, 32'd0);
      chk("rst_ab16", {a1, b1}, 32'd0);
      rst = 1'b0;
      tick(1);

      // 1: golden gates
      fault0 = 0;
      start_run(0, 0, 5'b00000, t0);
      tick(14);

      // 2: xor stuck at 0
      fault0 = 1;
      start_run(0, 2, 5'b10000, t0);
      tick(14);

      // 3: 16-bit, 6 vectors, no settle
      start_run(1, 0, 5'b00000, t0);
      tick(14);

      // 4: nand inverted, then restart the cycle after done with golden gates
      fault0 = 2;
      start_run(0, 4, 5'b00001, t0);
      tick(13);
      chk("t4_idle_err_cnt", {24'd0, err0}, 32'd4);
      fault0 = 0;
      start_run(0, 0, 5'b00000, t1);
      chk("t4_restart_cycle", t1, t0 + 14);
      chk("t4_clear_err_cnt", {24'd0, err0}, 32'd0);
      chk("t4_clear_fail_mask", {27'd0, mask0}, 32'd0);
      chk("t4_clear_pass", {31'd0, pass0}, 32'd0);
      tick(14);

      // 5: start while busy and while in DONE is ignored
      dc = done_cnt[0];
      start_run(0, 0, 5'b00000, t0);
      tick(1);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      tick(10);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      tick(4);
      chk("t5_done_pulses", done_cnt[0] - dc, 32'd1);
      chk("t5_idle_busy", {31'd0, busy0}, 32'd0);

      // 6: reset mid-run, then full rerun
      fault0 = 2;
      start_run(0, 4, 5'b00001, t0);
      tick(4);
      chk("t6_pre_rst_err_cnt", {24'd0, err0}, 32'd1);
      chk("t6_pre_rst_vecs_left", vq0.size(), 32'd2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6_rst_busy", {31'd0, busy0}, 32'd0);
      chk("t6_rst_ab", {30'd0, a0, b0}, 32'd0);
      chk("t6_rst_err_cnt", {24'd0, err0}, 32'd0);
      chk("t6_rst_fail_mask", {27'd0, mask0}, 32'd0);
      chk("t6_rst_vec_idx", {24'd0, idx0}, 32'd0);
      vq0.delete();
      dq0.delete();
      tick(2);
      chk("t6_stays_idle", {31'd0, busy0}, 32'd0);
      fault0 = 0;
      start_run(0, 0, 5'b00000, t0);
      tick(14);

      // nothing left outstanding
      chk("end_vq0", vq0.size(), 32'd0);
      chk("end_vq1", vq1.size(), 32'd0);
      chk("end_dq0", dq0.size(), 32'd0);
      chk("end_dq1", dq1.size(), 32'd0);
      chk("end_done_cnt0", done_cnt[0], 32'd6);
      chk("end_done_cnt1", done_cnt[1], 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
